// File: rtl/tomasulo_rs.sv
// Reservation station for one Tomasulo execution unit: holds dispatched ops until
// both operands arrive over the CDB, then issues the oldest ready entry.
package tomasulo_pkg;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOVI
    } opcode_t;

    typedef logic [31:0] word_t;
    typedef logic [15:0] imm_t;
    typedef logic [4:0]  tag_t;
    typedef logic [3:0]  robid_t;
    typedef logic [4:0]  reg_t;

    typedef struct packed {
        logic   vld;
        tag_t   tag;
        word_t  wdata;
        robid_t robid;
        reg_t   wa;
    } cdb_t;

    typedef struct packed {
        opcode_t     op;
        word_t [1:0] rdata;
        imm_t        imm;
        tag_t        tag;
        robid_t      robid;
        reg_t        wa;
    } issue_t;
endpackage

module tomasulo_rs
    import tomasulo_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   disp_vld,
    input  opcode_t                disp_op,
    input  imm_t                   disp_imm,
    input  tag_t                   disp_tag,
    input  robid_t                 disp_robid,
    input  reg_t                   disp_wa,
    input  logic [1:0]             disp_src_rdy,
    input  tag_t [1:0]             disp_src_tag,
    input  word_t [1:0]            disp_src_rdata,
    output logic                   disp_rdy_r,
    input  cdb_t                   cdb,
    output logic                   iss_vld,
    output issue_t                 iss,
    input  logic                   iss_busy_r,
    output logic [$clog2(N+1)-1:0] occ_r
);
    localparam int IW = $clog2(N);
    localparam int OW = $clog2(N+1);

    logic [N-1:0] vld;
    logic [N-1:0] age [N];
    opcode_t      op_q    [N];
    imm_t         imm_q   [N];
    tag_t         tag_q   [N];
    robid_t       robid_q [N];
    reg_t         wa_q    [N];
    logic [1:0]   rdy_q   [N];
    tag_t         stag_q  [N][2];
    word_t        data_q  [N][2];

    logic [IW-1:0] free_idx;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  cand;
    logic [N-1:0]  disp_we;
    logic          has_free;
    logic          disp_fire;
    logic [OW-1:0] occ_nxt;

    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so no path through the block leaves a value held and no latch is inferred.
    always_comb begin
        free_idx = '0;
        has_free = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!vld[i]) begin
                free_idx = IW'(i);
                has_free = 1'b1;
            end
        end

        for (int i = 0; i < N; i++) begin
            cand[i] = vld[i] & rdy_q[i][0] & rdy_q[i][1];
        end

        // The winner is the candidate with no older candidate.
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (cand[j] && age[j][i]) blocked = 1'b1;
            end
            if (cand[i] && !blocked) win_idx = IW'(i);
        end

        disp_fire = disp_vld & disp_rdy_r & ~flush & has_free;
        for (int i = 0; i < N; i++) begin
            disp_we[i] = disp_fire && (free_idx == IW'(i));
        end

        iss_vld = (|cand) & ~iss_busy_r & ~flush;
        iss     = '0;
        if (iss_vld) begin
            iss.op       = op_q[win_idx];
            iss.rdata[0] = data_q[win_idx][0];
            iss.rdata[1] = data_q[win_idx][1];
            iss.imm      = imm_q[win_idx];
            iss.tag      = tag_q[win_idx];
            iss.robid    = robid_q[win_idx];
            iss.wa       = wa_q[win_idx];
        end

        if (flush) occ_nxt = '0;
        else       occ_nxt = occ_r + OW'(disp_fire) - OW'(iss_vld);
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld        <= '0;
            occ_r      <= '0;
            disp_rdy_r <= 1'b1;
            for (int i = 0; i < N; i++) age[i] <= '0;
        end else begin
            occ_r      <= occ_nxt;
            disp_rdy_r <= (occ_nxt < OW'(N));
            assert ($onehot0(disp_we));
            if (flush) begin
                vld <= '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (disp_we[i]) begin
                        vld[i] <= 1'b1;
                        age[i] <= '0;
                    end else begin
                        if (iss_vld && (win_idx == IW'(i))) vld[i] <= 1'b0;
                        if (disp_fire) age[i][free_idx] <= vld[i];
                    end
                end
            end
        end
    end

    // NOTE: the payload array has no reset; it is only observed through vld,
    // which is reset, so clearing the storage would buy nothing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (disp_we[i]) begin
                op_q[i]    <= disp_op;
                imm_q[i]   <= disp_imm;
                tag_q[i]   <= disp_tag;
                robid_q[i] <= disp_robid;
                wa_q[i]    <= disp_wa;
            end
            for (int o = 0; o < 2; o++) begin
                if (disp_we[i]) begin
                    stag_q[i][o] <= disp_src_tag[o];
                    // Same-cycle CDB result bypasses into a not-yet-ready operand.
                    if (!disp_src_rdy[o] && cdb.vld && (disp_src_tag[o] == cdb.tag)) begin
                        rdy_q[i][o]  <= 1'b1;
                        data_q[i][o] <= cdb.wdata;
                    end else begin
                        rdy_q[i][o]  <= disp_src_rdy[o];
                        data_q[i][o] <= disp_src_rdata[o];
                    end
                end else if (vld[i] && !rdy_q[i][o] && cdb.vld && (stag_q[i][o] == cdb.tag)) begin
                    rdy_q[i][o]  <= 1'b1;
                    data_q[i][o] <= cdb.wdata;
                end
            end
        end
    end
endmodule
